street_tiles_generator: RTL and testbench

- Produces the scrolling white lane-divider tiles that feed the background mux: `streetTilesRequest[9:0]`, `streetTilesRGB[9:0][7:0]` and `streetRequest`.
- Per pixel, it decides which of NUM_TILES dashed tiles covers the current (pixelX, pixelY) and supplies that tile's colour.
- A per-frame vertical scroll offset, advanced by a game-speed value under a run/pause/idle FSM, animates the road.
- Outputs are registered, one cycle behind the pixel coordinates, aligned with the other drawing objects.

---
 rtl/street_tiles_generator.sv | 139 +++++++++++++
 tb/tb_street_tiles_generator.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/street_tiles_generator.sv
// Scrolling lane-divider tiles for the background mux: a run/pause/idle FSM advances a
// per-frame vertical offset, and a registered per-pixel stage reports which tile covers the pixel.
module street_tiles_generator #(
  parameter int NUM_TILES    = 10,
  parameter int STREET_LEFT  = 280,
  parameter int STREET_WIDTH = 80,
  parameter int TILE_X       = 316,
  parameter int TILE_WIDTH   = 8,
  parameter int TILE_HEIGHT  = 32,
  parameter int TILE_PITCH   = 48,
  parameter int SCREEN_W     = 640,
  parameter int SCREEN_H     = 480,
  parameter logic [7:0] TILE_COLOR = 8'hFF,
  parameter logic [7:0] EDGE_COLOR = 8'hB6
) (
  input  logic                          clk,
  input  logic                          resetN,
  input  logic                          startOfFrame,
  input  logic [10:0]                   pixelX,
  input  logic [10:0]                   pixelY,
  input  logic                          enable,
  input  logic                          pause,
  input  logic [3:0]                    speed,
  output logic                          streetRequest,
  output logic [NUM_TILES-1:0]          streetTilesRequest,
  output logic [NUM_TILES-1:0][7:0]     streetTilesRGB,
  output logic [8:0]                    scrollOffset,
  output logic [1:0]                    fsmState
);

  localparam logic [10:0] SW11    = 11'(SCREEN_W);
  localparam logic [10:0] SH11    = 11'(SCREEN_H);
  localparam logic [9:0]  SH10    = 10'(SCREEN_H);
  localparam logic [10:0] TX_LO   = 11'(TILE_X);
  localparam logic [10:0] TX_HI   = 11'(TILE_X + TILE_WIDTH);
  localparam logic [10:0] SL_LO   = 11'(STREET_LEFT);
  localparam logic [10:0] SL_HI   = 11'(STREET_LEFT + STREET_WIDTH);
  localparam logic [10:0] TH11    = 11'(TILE_HEIGHT);
  localparam logic [10:0] TH_LAST = 11'(TILE_HEIGHT - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    PAUSED = 2'd2
  } state_t;

  state_t     state;
  state_t     state_nxt;
  logic [8:0] offset;
  logic [8:0] offset_nxt;
  logic [9:0] offset_sum;

  // State register
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) state <= IDLE;
    else         state <= state_nxt;
  end

  // Next-state logic; losing enable always wins over pause
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (enable) state_nxt = RUN;
      RUN: begin
        if (!enable)    state_nxt = IDLE;
        else if (pause) state_nxt = PAUSED;
      end
      PAUSED: begin
        if (!enable)     state_nxt = IDLE;
        else if (!pause) state_nxt = RUN;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Output logic: scroll only on a frame pulse seen while currently running;
  // the sum never exceeds 494, so a single conditional subtract wraps it.
  always_comb begin
    offset_nxt = offset;
    offset_sum = {1'b0, offset} + {6'b0, speed};
    if (state_nxt == IDLE) begin
      offset_nxt = 9'd0;
    end else if (state == RUN && startOfFrame) begin
      if (offset_sum >= SH10) offset_nxt = 9'(offset_sum - SH10);
      else                    offset_nxt = offset_sum[8:0];
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) offset <= 9'd0;
    else         offset <= offset_nxt;
  end

  assign scrollOffset = offset;
  assign fsmState     = state;

  logic                      in_screen;
  logic                      in_tile_col;
  logic                      street_nxt;
  logic [NUM_TILES-1:0]      req_nxt;
  logic [NUM_TILES-1:0][7:0] rgb_nxt;
  logic [10:0]               top_a [NUM_TILES];
  logic [10:0]               row_a [NUM_TILES];

  // Tile geometry: row is the pixel's distance below the tile top, taken modulo the
  // screen height without ever going negative, so tiles wrap bottom-to-top seamlessly.
  always_comb begin
    in_screen   = (pixelX < SW11) && (pixelY < SH11);
    in_tile_col = (pixelX >= TX_LO) && (pixelX < TX_HI);
    street_nxt  = in_screen && (pixelX >= SL_LO) && (pixelX < SL_HI);
    req_nxt     = '0;
    rgb_nxt     = '0;
    for (int i = 0; i < NUM_TILES; i++) begin
      top_a[i] = 11'(i * TILE_PITCH) + {2'b00, offset};
      if (top_a[i] >= SH11) top_a[i] = top_a[i] - SH11;
      if (pixelY >= top_a[i]) row_a[i] = pixelY - top_a[i];
      else                    row_a[i] = pixelY + SH11 - top_a[i];
      req_nxt[i] = in_screen && in_tile_col && (row_a[i] < TH11);
      if (req_nxt[i]) begin
        if (row_a[i] == 11'd0 || row_a[i] == TH_LAST) rgb_nxt[i] = EDGE_COLOR;
        else                                          rgb_nxt[i] = TILE_COLOR;
      end
    end
  end

  // One-cycle output register keeps alignment with the other drawing objects
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      streetRequest      <= 1'b0;
      streetTilesRequest <= '0;
      streetTilesRGB     <= '0;
    end else begin
      streetRequest      <= street_nxt;
      streetTilesRequest <= req_nxt;
      streetTilesRGB     <= rgb_nxt;
    end
  end

endmodule

// File: tb/tb_street_tiles_generator.sv
// Directed bench for street_tiles_generator: geometry, scrolling, wrap, FSM and async reset.
module tb_street_tiles_generator;

  logic             clk = 1'b0;
  logic             resetN = 1'b0;
  logic             startOfFrame = 1'b0;
  logic [10:0]      pixelX = '0;
  logic [10:0]      pixelY = '0;
  logic             enable = 1'b0;
  logic             pause = 1'b0;
  logic [3:0]       speed = '0;
  logic             streetRequest;
  logic [9:0]       streetTilesRequest;
  logic [9:0][7:0]  streetTilesRGB;
  logic [8:0]       scrollOffset;
  logic [1:0]       fsmState;

  int checks = 0;
  int failures = 0;

  street_tiles_generator dut (
    .clk                (clk),
    .resetN             (resetN),
    .startOfFrame       (startOfFrame),
    .pixelX             (pixelX),
    .pixelY             (pixelY),
    .enable             (enable),
    .pause              (pause),
    .speed              (speed),
    .streetRequest      (streetRequest),
    .streetTilesRequest (streetTilesRequest),
    .streetTilesRGB     (streetTilesRGB),
    .scrollOffset       (scrollOffset),
    .fsmState           (fsmState)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [79:0] obs, input logic [79:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic frame(input logic [3:0] spd);
    speed = spd;
    startOfFrame = 1'b1;
    step();
    startOfFrame = 1'b0;
  endtask

  task automatic pix(input string tag, input int x, input int y,
                     input logic [9:0] ereq, input logic [7:0] ecol, input logic estreet);
    logic [9:0][7:0] ergb;
    pixelX = 11'(x);
    pixelY = 11'(y);
    step();
    ergb = '0;
    for (int i = 0; i < 10; i++) if (ereq[i]) ergb[i] = ecol;
    check({tag, "_req"}, 80'(streetTilesRequest), 80'(ereq));
    check({tag, "_rgb"}, streetTilesRGB, ergb);
    check({tag, "_street"}, 80'(streetRequest), 80'(estreet));
  endtask

  initial begin
    // Reset
    #12;
    check("rst_offset", 80'(scrollOffset), 80'd0);
    check("rst_req", 80'(streetTilesRequest), 80'd0);
    check("rst_rgb", streetTilesRGB, 80'd0);
    check("rst_state", 80'(fsmState), 80'd0);
    @(negedge clk);
    resetN = 1'b1;
    step();

    // Static geometry, offset 0
    pix("p316_0",   316, 0,   10'b0000000001, 8'hB6, 1'b1);
    pix("p320_10",  320, 10,  10'b0000000001, 8'hFF, 1'b1);
    pix("p320_31",  320, 31,  10'b0000000001, 8'hB6, 1'b1);
    pix("p320_40",  320, 40,  10'b0000000000, 8'h00, 1'b1);
    pix("p320_48",  320, 48,  10'b0000000010, 8'hB6, 1'b1);
    pix("p300_10",  300, 10,  10'b0000000000, 8'h00, 1'b1);
    pix("p323_10",  323, 10,  10'b0000000001, 8'hFF, 1'b1);
    pix("p324_10",  324, 10,  10'b0000000000, 8'h00, 1'b1);
    pix("p279_10",  279, 10,  10'b0000000000, 8'h00, 1'b0);
    pix("p360_10",  360, 10,  10'b0000000000, 8'h00, 1'b0);
    pix("p320_463", 320, 463, 10'b1000000000, 8'hB6, 1'b1);
    pix("p316_480", 316, 480, 10'b0000000000, 8'h00, 1'b0);
    pix("p640_0",   640, 0,   10'b0000000000, 8'h00, 1'b0);

    // Frame pulses while idle are ignored
    frame(4'd5);
    check("idle_nosc", 80'(scrollOffset), 80'd0);

    // Scroll
    enable = 1'b1;
    step();
    check("state_run", 80'(fsmState), 80'd1);
    repeat (3) frame(4'd5);
    check("scroll15", 80'(scrollOffset), 80'd15);
    pix("s320_15",  320, 15,  10'b0000000001, 8'hB6, 1'b1);
    pix("s320_14",  320, 14,  10'b0000000000, 8'h00, 1'b1);
    pix("s320_478", 320, 478, 10'b1000000000, 8'hB6, 1'b1);
    pix("s320_479", 320, 479, 10'b0000000000, 8'h00, 1'b1);

    // Clear and build up to 460
    enable = 1'b0;
    step();
    check("clr_offset", 80'(scrollOffset), 80'd0);
    check("clr_state", 80'(fsmState), 80'd0);
    enable = 1'b1;
    step();
    repeat (46) frame(4'd10);
    check("off460", 80'(scrollOffset), 80'd460);
    pix("w320_460", 320, 460, 10'b0000000001, 8'hB6, 1'b1);
    pix("w320_470", 320, 470, 10'b0000000001, 8'hFF, 1'b1);
    pix("w320_10",  320, 10,  10'b0000000001, 8'hFF, 1'b1);
    pix("w320_11",  320, 11,  10'b0000000001, 8'hB6, 1'b1);
    pix("w320_12",  320, 12,  10'b0000000000, 8'h00, 1'b1);
    pix("w320_28",  320, 28,  10'b0000000010, 8'hB6, 1'b1);
    frame(4'd10);
    check("off470", 80'(scrollOffset), 80'd470);
    frame(4'd15);
    check("wrap5", 80'(scrollOffset), 80'd5);

    // Pause behaviour
    pause = 1'b1;
    step();
    check("state_paused", 80'(fsmState), 80'd2);
    repeat (3) frame(4'd7);
    check("paused_hold", 80'(scrollOffset), 80'd5);
    pause = 1'b0;
    frame(4'd9);
    check("resume_ignored", 80'(scrollOffset), 80'd5);
    check("state_resume", 80'(fsmState), 80'd1);
    frame(4'd2);
    check("plus2", 80'(scrollOffset), 80'd7);
    frame(4'd0);
    check("speed0_hold", 80'(scrollOffset), 80'd7);

    // Disable coincident with a frame pulse clears
    enable = 1'b0;
    frame(4'd2);
    check("dis_clear", 80'(scrollOffset), 80'd0);
    check("dis_state", 80'(fsmState), 80'd0);

    // Async reset mid-frame with offset 123
    enable = 1'b1;
    step();
    repeat (8) frame(4'd15);
    frame(4'd3);
    check("off123", 80'(scrollOffset), 80'd123);
    pix("a320_123", 320, 123, 10'b0000000001, 8'hB6, 1'b1);
    #2;
    resetN = 1'b0;
    #1;
    check("arst_offset", 80'(scrollOffset), 80'd0);
    check("arst_req", 80'(streetTilesRequest), 80'd0);
    check("arst_rgb", streetTilesRGB, 80'd0);
    check("arst_street", 80'(streetRequest), 80'd0);
    check("arst_state", 80'(fsmState), 80'd0);
    enable = 1'b0;
    @(negedge clk);
    resetN = 1'b1;
    step();
    repeat (2) frame(4'd5);
    check("post_rst_idle", 80'(scrollOffset), 80'd0);
    enable = 1'b1;
    step();
    frame(4'd5);
    check("post_rst_run", 80'(scrollOffset), 80'd5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    failures++;
    $display("FAIL timeout got=running expected=finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
